req_serializer: RTL

- Collects up to N_REQ asynchronous-in-time but clock-synchronous request lines into a pending register.
- Emits pending requests one at a time as a binary index on a valid/ready handshake; bit 0 has highest priority.
- Sits directly upstream of the consumer that services request codes, e.g. an interrupt dispatcher or a log writer.
- Converts a bursty bit-vector of events into an ordered, lossless stream of indices, and flags any event that could not be held.

---
 rtl/req_serializer_pkg.sv | 13 +
 rtl/req_serializer_lowest_index_enc.sv | 23 ++
 rtl/req_serializer.sv | 115 +++++++++++
 3 files changed

// File: rtl/req_serializer_pkg.sv
// Shared types and constants for req_serializer.
package req_serializer_pkg;

  typedef enum logic [0:0] {ST_IDLE, ST_OFFER} state_e;

  localparam int unsigned DEFAULT_N_REQ = 8;

  // Keeps the code width at least one bit for degenerate sizes.
  function automatic int unsigned code_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/req_serializer_lowest_index_enc.sv
// Combinational priority encoder: lowest set index wins, plus an any-set flag.
module lowest_index_enc
  import req_serializer_pkg::*;
#(
  parameter int unsigned N_REQ  = DEFAULT_N_REQ,
  parameter int unsigned CODE_W = code_w(N_REQ)
) (
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  always_comb begin
    code = '0;
    // Scan downward so the lowest set index is written last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) code = CODE_W'(i);
    end
  end

  assign any = |vec;

endmodule

// File: rtl/req_serializer.sv
// Serializes a vector of request events into a valid/ready stream of indices.
// Optional LEVEL_MODE_EN: requests are level-sensitive and lost is tied low.
module req_serializer
  import req_serializer_pkg::*;
#(
  parameter int unsigned N_REQ = DEFAULT_N_REQ,
  localparam int unsigned CODE_W = code_w(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [N_REQ-1:0]  pending,
  output logic              lost
);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   pending_q, pending_d, pending_kept;
  logic [N_REQ-1:0]   rise, clr;
  logic [CODE_W-1:0]  code_q, code_d, enc_code;
  logic               enc_any, accept;

`ifdef LEVEL_MODE_EN
  assign rise = req;
  assign lost = 1'b0;
`else
  logic [N_REQ-1:0] req_q;
  logic             armed_q;
  logic             lost_q;

  // armed_q masks the first cycle after reset so a line held high is not an event.
  assign rise = armed_q ? (req & ~req_q) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      armed_q <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      req_q   <= req;
      armed_q <= 1'b1;
      lost_q  <= |(rise & pending_q & ~clr);
    end
  end

  assign lost = lost_q;
`endif

  assign accept = (state_q == ST_OFFER) && out_ready;

  always_comb begin
    clr = '0;
    if (accept) clr[code_q] = 1'b1;
  end

  assign pending_kept = pending_q & ~clr;
  // A set landing on the bit being cleared wins.
  assign pending_d    = pending_kept | rise;

  lowest_index_enc #(
    .N_REQ  (N_REQ),
    .CODE_W (CODE_W)
  ) u_enc (
    .vec  (pending_kept),
    .code (enc_code),
    .any  (enc_any)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and code selection.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enc_any) begin
          code_d  = enc_code;
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (accept) begin
          if (enc_any) code_d = enc_code;
          else         state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    out_valid = (state_q == ST_OFFER);
    out_code  = code_q;
    pending   = pending_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      code_q    <= '0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
    end
  end

endmodule
